// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: takes framed commands and turns them into writes and reads on a
// single-port synchronous RAM. Separate write and read pointers are loaded by address
// frames. When AUTO_INC is set, each data access post-increments its pointer.
//
// Frame on data_in: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload
//   00 write address   wptr <= payload (range checked)
//   01 data write      mem[wptr] <= payload
//   10 read address    rptr <= payload (range checked)
//   11 read data       mem[rptr] -> data_out, two edges after accept
//
// Ports
//   sys_clock  in   sole clock, rising edge
//   reset      in   synchronous active-high reset
//   rx_valid   in   frame on data_in valid
//   rx_ready   out  block can accept a frame (IDLE only)
//   data_in    in   command frame
//   data_out   out  read response {2'b00, word}, zero when tx_valid=0
//   tx_valid   out  data_out valid
//   tx_ready   in   consumer accepts data_out
//   addr_err   out  one-cycle pulse after an out-of-range address frame
module ram_burst_ctrl #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 9,
  parameter int unsigned AUTO_INC = 1
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [DATA_W+1:0] data_in,
  output logic [DATA_W+1:0] data_out,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              addr_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  localparam logic [1:0] OpWrAddr = 2'b00;
  localparam logic [1:0] OpWrData = 2'b01;
  localparam logic [1:0] OpRdAddr = 2'b10;
  localparam logic [1:0] OpRdData = 2'b11;

  typedef enum logic [1:0] {StIdle, StRdFetch, StTxHold} state_e;

  state_e state_q, state_d;

  logic [1:0]        opcode;
  logic [DATA_W-1:0] payload;
  logic              accept;
  logic              in_range;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic              addr_err_q, addr_err_d;
  logic              tx_valid_q, tx_valid_d;
  logic [DATA_W+1:0] data_out_q, data_out_d;

  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem [Depth];
  logic [DATA_W-1:0] rd_data_q;

  assign opcode  = data_in[DATA_W+1:DATA_W];
  assign payload = data_in[DATA_W-1:0];
  assign accept  = rx_valid & rx_ready;
  // Address frames must fit in ADDR_W bits; any set upper payload bit is an error.
  assign in_range = (payload >> ADDR_W) == '0;

  // State register
  always_ff @(posedge sys_clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept && opcode == OpRdData) begin
          state_d = StRdFetch;
        end
      end
      StRdFetch: state_d = StTxHold;
      StTxHold: begin
        // tx_valid is always 1 here, so tx_ready alone completes the handshake.
        if (tx_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic: rx_ready is decoded from state; the response path is registered.
  always_comb begin
    rx_ready   = (state_q == StIdle);
    tx_valid_d = tx_valid_q;
    data_out_d = data_out_q;
    unique case (state_q)
      StRdFetch: begin
        tx_valid_d = 1'b1;
        data_out_d = {2'b00, rd_data_q};
      end
      StTxHold: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          data_out_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Command decode: pointer updates, error pulse and memory strobes.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    addr_err_d = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    if (accept && !reset) begin
      unique case (opcode)
        OpWrAddr: begin
          if (in_range) begin
            wptr_d = payload[ADDR_W-1:0];
          end else begin
            addr_err_d = 1'b1;
          end
        end
        OpWrData: begin
          mem_we = 1'b1;
          if (AUTO_INC != 0) begin
            wptr_d = wptr_q + ADDR_W'(1);
          end
        end
        OpRdAddr: begin
          if (in_range) begin
            rptr_d = payload[ADDR_W-1:0];
          end else begin
            addr_err_d = 1'b1;
          end
        end
        OpRdData: begin
          mem_re = 1'b1;
          if (AUTO_INC != 0) begin
            rptr_d = rptr_q + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      addr_err_q <= 1'b0;
      tx_valid_q <= 1'b0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      addr_err_q <= addr_err_d;
      tx_valid_q <= tx_valid_d;
      data_out_q <= data_out_d;
    end
  end

  // Single-port RAM with synchronous read and write. No reset so it maps to block RAM.
  // Reads and writes come from different frames and can never share an edge.
  always_ff @(posedge sys_clock) begin
    if (mem_we) begin
      mem[wptr_q] <= payload;
    end
    if (mem_re) begin
      rd_data_q <= mem[rptr_q];
    end
  end

  assign tx_valid = tx_valid_q;
  assign data_out = data_out_q;
  assign addr_err = addr_err_q;

endmodule

// File: doc/ram_burst_ctrl.md
RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16: memory word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9: address width; DEPTH = 2**ADDR_W words.
REQ-003 SHALL have parameter AUTO_INC, default 1: 1 = pointer post-increment on data write/read; 0 = pointers static.
REQ-004 SHALL have port sys_clock  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rx_valid  input  1  frame on data_in valid.
REQ-007 SHALL have port rx_ready  output  1  block can accept a frame.
REQ-008 SHALL have port data_in  input  DATA_W+2  frame: [DATA_W+1:DATA_W] opcode, [DATA_W-1:0] payload.
REQ-009 SHALL have port data_out  output  DATA_W+2  read response {2'b00, word}.
REQ-010 SHALL have port tx_valid  output  1  data_out valid.
REQ-011 SHALL have port tx_ready  input  1  consumer accepts data_out.
REQ-012 SHALL have port addr_err  output  1  one-cycle pulse on out-of-range address frame.

Function
REQ-013 SHALL accept a frame only on a rising edge where rx_valid=1 and rx_ready=1; all other frames are ignored with no state change.
REQ-014 SHALL implement FSM states IDLE, RD_FETCH, TX_HOLD; rx_ready=1 only in IDLE.
REQ-015 Opcode 00 (write address) SHALL load wptr <= payload[ADDR_W-1:0] when payload[DATA_W-1:ADDR_W]==0; otherwise SHALL leave wptr unchanged and pulse addr_err for one cycle.
REQ-016 Opcode 01 (data write) SHALL write mem[wptr] <= payload; if AUTO_INC=1, SHALL also set wptr <= (wptr+1) mod DEPTH.
REQ-017 Opcode 10 (read address) SHALL load rptr using the same range check and addr_err rule as REQ-015.
REQ-018 Opcode 11 (read data) SHALL register mem[rptr] into an internal read register and move IDLE->RD_FETCH; if AUTO_INC=1, SHALL also set rptr <= (rptr+1) mod DEPTH on the same edge.
REQ-019 From RD_FETCH, SHALL on the next edge set data_out <= {2'b00, read register}, set tx_valid <= 1, and move to TX_HOLD.
REQ-020 Read latency SHALL be exactly 2 edges from the opcode-11 accept edge to tx_valid=1.
REQ-021 In TX_HOLD, SHALL hold data_out and tx_valid stable while tx_ready=0.
REQ-022 On an edge with tx_valid=1 and tx_ready=1, SHALL clear tx_valid, drive data_out to 0, and move to IDLE; rx_ready SHALL be 1 in the following cycle.
REQ-023 data_out SHALL be 0 whenever tx_valid=0.
REQ-024 Pointer wrap SHALL be silent: 2**ADDR_W-1 increments to 0 with no addr_err.
REQ-025 Opcode 01 and 11 payload range SHALL not be checked (01 writes full payload; 11 payload is ignored).
REQ-026 addr_err SHALL otherwise be 0 and SHALL never coincide with a pointer update.
REQ-027 Memory SHALL be a single-port array inferable as block RAM, with synchronous read and synchronous write.

Reset
REQ-028 When reset=1 at an edge, SHALL set state=IDLE, wptr=0, rptr=0, tx_valid=0, data_out=0, addr_err=0; rx_ready SHALL be 1 after reset.
REQ-029 reset SHALL take priority over every other input, including mid-RD_FETCH or mid-TX_HOLD, where a pending response is discarded.
REQ-030 Memory contents SHALL NOT be cleared by reset; contents are undefined until written.

Verification (DATA_W=16, ADDR_W=9, AUTO_INC=1)
REQ-031 Reset: assert reset 2 cycles -> tx_valid=0, data_out=0, addr_err=0, rx_ready=1.
REQ-032 Burst write/read: frames 0x00005, 0x1ABCD, 0x11234, 0x20005, 0x30000, 0x30000 with tx_ready=1 -> mem[5]=0xABCD, mem[6]=0x1234; responses 0x0ABCD then 0x01234; each tx_valid exactly 2 edges after its accept.
REQ-033 Wrap: frames 0x001FF, 0x1AAAA, 0x15555, then 0x201FF and two 0x30000 reads -> responses 0x0AAAA (addr 511) then 0x05555 (addr 0), no addr_err.
REQ-034 Range error: frame 0x00200 after wptr=5 -> addr_err=1 for one cycle; a following 0x1BEEF writes mem[5].
REQ-035 Backpressure: tx_ready=0 for 5 cycles after response 0x0ABCD -> data_out and tx_valid stable, rx_ready=0, rx_valid frames presented meanwhile have no effect; tx_ready=1 -> handshake, then IDLE.
REQ-036 Reset in TX_HOLD: reset=1 while tx_valid=1 -> next edge tx_valid=0, data_out=0, rx_ready=1, wptr=rptr=0; previously written mem[5] is still readable.
